// File: rtl/sram_top_if.sv
// Bus bundle for sram_top: serial write data, strobes, address and read-out.
// The master drives stimulus; the slave (the SRAM) returns registered read data.
interface sram_top_if #(
  parameter int ROWS = 4,
  parameter int COLS = 8
);
  logic            serial_in;
  logic            shift;
  logic            w_en;
  logic            r_en;
  logic [ROWS-1:0] addr;
  logic            data_valid;
  logic [COLS-1:0] data_out;

  modport master (
    output serial_in, shift, w_en, r_en, addr,
    input  data_valid, data_out
  );

  modport slave (
    input  serial_in, shift, w_en, r_en, addr,
    output data_valid, data_out
  );
endinterface

// File: rtl/sram_top.sv
// Small serially-loaded SRAM: a shift-in write register, a flop-based bit-cell
// array with row decode, and a read-out register that generates data_valid.

module sram_top_wreg #(
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            shift,
  input  logic            serial_in,
  output logic [COLS-1:0] wreg_o
);
  logic [COLS-1:0] wreg_q;
  logic [COLS-1:0] wreg_d;

  always_comb begin
    wreg_d = wreg_q;
    if (shift) wreg_d = {wreg_q[COLS-2:0], serial_in};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) wreg_q <= '0;
    else         wreg_q <= wreg_d;
  end

  assign wreg_o = wreg_q;
endmodule

module sram_top_array #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            w_en,
  input  logic [ROWS-1:0] addr,
  input  logic [COLS-1:0] wdata,
  output logic [COLS-1:0] rdata
);
  localparam int DEPTH = 2 ** ROWS;

  logic [COLS-1:0] row_q [DEPTH];
  logic [COLS-1:0] row_d [DEPTH];

  // Flops rather than inferred RAM: every word must clear on reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    logic row_sel;
    assign row_sel = w_en && (addr == ROWS'(gi));

    always_comb begin
      row_d[gi] = row_q[gi];
      if (row_sel) row_d[gi] = wdata;
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) row_q[gi] <= '0;
      else         row_q[gi] <= row_d[gi];
    end
  end

  // Pre-edge contents, so a same-edge write yields read-before-write.
  assign rdata = row_q[addr];
endmodule

module sram_top_rdout #(
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            r_en,
  input  logic [COLS-1:0] rdata,
  output logic            data_valid,
  output logic [COLS-1:0] data_out
);
  logic [COLS-1:0] data_out_q;
  logic [COLS-1:0] data_out_d;
  logic            data_valid_q;

  always_comb begin
    data_out_d = data_out_q;
    if (r_en) data_out_d = rdata;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= r_en;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
endmodule

module sram_top #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic       clk,
  input  logic       arst_n,
  sram_top_if.slave  bus
);
  logic [COLS-1:0] wreg;
  logic [COLS-1:0] rdata;

  sram_top_wreg #(.COLS(COLS)) u_wreg (
    .clk       (clk),
    .arst_n    (arst_n),
    .shift     (bus.shift),
    .serial_in (bus.serial_in),
    .wreg_o    (wreg)
  );

  sram_top_array #(.ROWS(ROWS), .COLS(COLS)) u_array (
    .clk    (clk),
    .arst_n (arst_n),
    .w_en   (bus.w_en),
    .addr   (bus.addr),
    .wdata  (wreg),
    .rdata  (rdata)
  );

  sram_top_rdout #(.COLS(COLS)) u_rdout (
    .clk        (clk),
    .arst_n     (arst_n),
    .r_en       (bus.r_en),
    .rdata      (rdata),
    .data_valid (bus.data_valid),
    .data_out   (bus.data_out)
  );
endmodule

// File: tb/tb_sram_top.sv
// Self-checking bench for sram_top: a behavioural model pushes expected read
// data to a scoreboard queue, popped and compared when the read completes.
module tb_sram_top;
  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int DEPTH = 2 ** ROWS;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  sram_top_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  sram_top #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [COLS-1:0] mem_m [DEPTH];
  logic [COLS-1:0] wreg_m;
  logic [COLS-1:0] sb [$];
  logic [COLS-1:0] exp_v;
  logic [COLS-1:0] last_out;

  task automatic idle();
    bus.shift = 1'b0; bus.serial_in = 1'b0; bus.w_en = 1'b0;
    bus.r_en = 1'b0; bus.addr = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    wreg_m = '0;
    last_out = '0;
    sb.delete();
  endtask

  // Drive one cycle, update the model, then sample 1 time unit after the edge.
  task automatic step(input logic sh, input logic sin, input logic we,
                      input logic re, input logic [ROWS-1:0] a);
    bus.shift = sh; bus.serial_in = sin; bus.w_en = we; bus.r_en = re; bus.addr = a;
    if (re) sb.push_back(mem_m[a]);
    if (we) mem_m[a] = wreg_m;
    if (sh) wreg_m = {wreg_m[COLS-2:0], sin};
    @(posedge clk); #1;
    idle();
  endtask

  task automatic shift_in(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, 1'b0, '0);
  endtask

  task automatic write_word(input logic [COLS-1:0] v, input logic [ROWS-1:0] a);
    shift_in({8'h00, v}, COLS);
    step(1'b0, 1'b0, 1'b1, 1'b0, a);
  endtask

  // Issue a read and pop its expected value into exp_v.
  task automatic rd(input logic [ROWS-1:0] a);
    step(1'b0, 1'b0, 1'b0, 1'b1, a);
    exp_v = sb.pop_front();
    last_out = exp_v;
  endtask

  task automatic test_reset();
    idle();
    model_clear();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.data_out !== '0 || bus.data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h valid=%b want out=00 valid=0", bus.data_out, bus.data_valid);
    end
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    rd('0);
    n_checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL reset_rd0: got out=%h valid=%b want out=%h valid=1", bus.data_out, bus.data_valid, exp_v);
    end
    $display("read addr 0 -> %h", bus.data_out);
    rd(ROWS'(DEPTH - 1));
    n_checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL reset_rd_top: got out=%h valid=%b want out=%h valid=1", bus.data_out, bus.data_valid, exp_v);
    end
    $display("read addr %0d -> %h", DEPTH - 1, bus.data_out);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (bus.data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_drop: got valid=%b want 0", bus.data_valid);
    end
  endtask

  task automatic test_write_read_a5();
    write_word(8'hA5, 4'h3);
    n_checks++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== last_out) begin
      n_fail++;
      $display("FAIL write_no_effect: got out=%h valid=%b want out=%h valid=0", bus.data_out, bus.data_valid, last_out);
    end
    rd(4'h3);
    n_checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL a5_read: got out=%h valid=%b want out=%h valid=1", bus.data_out, bus.data_valid, exp_v);
    end
    $display("write A5 @3, read @3 -> %h", bus.data_out);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== last_out) begin
      n_fail++;
      $display("FAIL a5_hold: got out=%h valid=%b want out=%h valid=0", bus.data_out, bus.data_valid, last_out);
    end
  endtask

  task automatic test_boundary();
    write_word(8'h3C, 4'h0);
    write_word(8'hC3, 4'hF);
    rd(4'h0);
    n_checks++;
    if (bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL bnd_rd0: got %h want %h", bus.data_out, exp_v);
    end
    $display("read @0 -> %h", bus.data_out);
    rd(4'hF);
    n_checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL bnd_rdF: got out=%h valid=%b want out=%h valid=1", bus.data_out, bus.data_valid, exp_v);
    end
    $display("read @F -> %h", bus.data_out);
    rd(4'h3);
    n_checks++;
    if (bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL bnd_rd3: got %h want %h", bus.data_out, exp_v);
    end
    $display("read @3 -> %h", bus.data_out);
  endtask

  task automatic test_rbw();
    write_word(8'h11, 4'h5);
    shift_in(16'h0022, COLS);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
    exp_v = sb.pop_front();
    last_out = exp_v;
    n_checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL rbw_old: got out=%h valid=%b want out=%h valid=1", bus.data_out, bus.data_valid, exp_v);
    end
    $display("write+read @5 -> %h", bus.data_out);
    rd(4'h5);
    n_checks++;
    if (bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL rbw_new: got %h want %h", bus.data_out, exp_v);
    end
    $display("read @5 -> %h", bus.data_out);
  endtask

  task automatic test_back_to_back();
    logic [ROWS-1:0] addrs [3];
    addrs[0] = 4'h0; addrs[1] = 4'hF; addrs[2] = 4'h5;
    for (int i = 0; i < 3; i++) begin
      rd(addrs[i]);
      n_checks++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_rd%0d: got out=%h valid=%b want out=%h valid=1", i, bus.data_out, bus.data_valid, exp_v);
      end
      $display("held read %0d @%h -> %h", i, addrs[i], bus.data_out);
    end
    // 10 shifts: the two oldest bits fall off, leaving 0x5A.
    shift_in(16'h035A, 10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h7);
    rd(4'h7);
    n_checks++;
    if (bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL long_shift: got %h want %h", bus.data_out, exp_v);
    end
    $display("10-bit shift, read @7 -> %h", bus.data_out);
  endtask

  task automatic test_async_reset();
    rd(4'h7);
    #2 arst_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (bus.data_out !== '0 || bus.data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: got out=%h valid=%b want out=00 valid=0", bus.data_out, bus.data_valid);
    end
    // Activity while held in reset must leave no trace.
    bus.shift = 1'b1; bus.serial_in = 1'b1; bus.w_en = 1'b1; bus.r_en = 1'b1; bus.addr = 4'h7;
    @(posedge clk); #1;
    idle();
    @(negedge clk); arst_n = 1'b1;
    rd(4'h7);
    n_checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL arst_rd7: got out=%h valid=%b want out=%h valid=1", bus.data_out, bus.data_valid, exp_v);
    end
    $display("after reset read @7 -> %h", bus.data_out);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h9);
    rd(4'h9);
    n_checks++;
    if (bus.data_out !== exp_v) begin
      n_fail++;
      $display("FAIL arst_wreg: got %h want %h", bus.data_out, exp_v);
    end
    $display("after reset write/read @9 -> %h", bus.data_out);
  endtask

  initial begin
    test_reset();
    test_write_read_a5();
    test_boundary();
    test_rbw();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_top.md
SRAM_TOP -- requirements
Module: sram_top

Interface
REQ-001 Parameter ROWS, default 4: address width in bits; array depth SHALL be 2**ROWS words.
REQ-002 Parameter COLS, default 8: word width in bits; also the serial shift-register length.
REQ-003 clk  input  1  single clock; all sequential logic SHALL be rising-edge triggered.
REQ-004 arst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronised by the system.
REQ-005 serial_in  input  1  serial write-data bit, MSB first.
REQ-006 shift  input  1  when high at a clock edge, serial_in SHALL be shifted into the write register.
REQ-007 w_en  input  1  write strobe: commit the write register to the word at addr.
REQ-008 r_en  input  1  read strobe: fetch the word at addr.
REQ-009 addr  input  ROWS  word address for write and read.
REQ-010 data_valid  output  1  one-cycle pulse marking new read data on data_out.
REQ-011 data_out  output  COLS  registered read data.

Function
REQ-012 Write register: COLS-bit register; on each edge with shift=1 it SHALL load {wreg[COLS-2:0], serial_in}, so after COLS shifts the first bit sent is at bit COLS-1.
REQ-013 With shift=0 the write register SHALL hold its value; more than COLS shifts SHALL discard the oldest bits.
REQ-014 Write: on an edge with w_en=1, mem[addr] SHALL take the write register value as it was before that edge; write latency is 1 cycle.
REQ-015 Shift and w_en on the same edge: the write SHALL use the pre-shift value and the shift SHALL still occur.
REQ-016 Read: on an edge with r_en=1, data_out SHALL load mem[addr] and data_valid SHALL go high. Both are visible after that same edge, which gives a latency of 1 cycle.
REQ-017 data_valid SHALL be high for exactly the one cycle following each edge that samples r_en=1. It SHALL stay high continuously while r_en is held high.
REQ-018 With r_en=0, data_out SHALL hold its last read value; only data_valid drops.
REQ-019 w_en and r_en on the same edge, same address: the read SHALL return the old contents (read-before-write), and the write SHALL still complete.
REQ-020 addr is sampled only on edges with w_en or r_en high; every value 0..2**ROWS-1 is valid, with no wrap or error condition.
REQ-021 Writes SHALL never change data_out or data_valid.
REQ-022 The design SHALL be split internally into three sub-blocks: a serial-to-parallel write register, a 2**ROWS x COLS bit-cell array with row decode, and a read-out register with data_valid generation.

Reset
REQ-023 While arst_n=0, asynchronously: write register = 0, every memory word = 0, data_out = 0, data_valid = 0.
REQ-024 Reset asserted mid-operation SHALL abort any shift, write or read in progress, with no partial update after release.
REQ-025 The first active edge after arst_n rises SHALL behave normally.

Verification
REQ-026 Reset, then read addr 0 and addr 2**ROWS-1 -> data_out=0x00, with data_valid pulsed once per read.
REQ-027 ROWS=4, COLS=8: shift 0xA5 MSB-first (8 shifts, bits 1,0,1,0,0,1,0,1), then w_en at addr 0x3, then r_en at addr 0x3 -> data_out=0xA5 and data_valid=1 for one cycle, then data_valid=0 with data_out still 0xA5.
REQ-028 Write 0x3C to addr 0x0 and 0xC3 to addr 0xF, read both back -> 0x3C, 0xC3; read addr 0x3 -> 0xA5 is unchanged.
REQ-029 Write 0x11 to addr 5, load 0x22, then assert w_en and r_en together at addr 5 -> data_out=0x11; the next read -> 0x22.
REQ-030 Hold r_en for 3 cycles -> data_valid high for 3 consecutive cycles; shift 10 bits ending in 0x5A -> write/read returns 0x5A.
REQ-031 Assert arst_n=0 between clock edges after writing -> outputs are 0 immediately; a read after release -> 0x00.
